// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, display mode encodings and sequencer/bus state types
package lcd_pkg;
    localparam logic [7:0] LCD_FUNC_SET   = 8'h38;
    localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
    localparam logic [7:0] LCD_ENTRY      = 8'h06;
    localparam logic [7:0] LCD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_LINE1      = 8'h80;
    localparam logic [7:0] LCD_LINE2      = 8'hC0;
    localparam logic [7:0] LCD_BLANK_CHAR = 8'h20;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_BLANK  = 2'b10;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2
    } seq_state_e;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EN,
        PH_HOLD,
        PH_WAIT
    } bus_phase_e;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        return i == 2'd0 ? LCD_FUNC_SET : i == 2'd1 ? LCD_DISP_ON : i == 2'd2 ? LCD_ENTRY : LCD_CLEAR;
    endfunction
endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: one timed HD44780 write cycle (SETUP, EN, HOLD, WAIT) per start; done pulses on the last WAIT cycle
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 16,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] wr_byte,
    input  logic       long_wait,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_dat,
    output logic       done
);
    localparam int T_A   = T_SETUP > T_EN ? T_SETUP : T_EN;
    localparam int T_B   = T_HOLD > T_CMD ? T_HOLD : T_CMD;
    localparam int T_C   = T_A > T_B ? T_A : T_B;
    localparam int T_MAX = T_C > T_CLR ? T_C : T_CLR;
    localparam int CW    = $clog2(T_MAX + 1);

    bus_phase_e phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic rs_q, rs_d, en_q, en_d, long_q, long_d, last;
    logic [7:0] dat_q, dat_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            long_q  <= 1'b0;
            dat_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            long_q  <= long_d;
            dat_q   <= dat_d;
        end
    end

    // Start wins over the phase walk so the next byte follows the last WAIT cycle with no gap.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = phase_q == PH_IDLE ? '0 : cnt_q + CW'(1);
        rs_d    = rs_q;
        dat_d   = dat_q;
        long_d  = long_q;
        last    = cnt_q == (phase_q == PH_SETUP ? CW'(T_SETUP - 1) :
                            phase_q == PH_EN    ? CW'(T_EN - 1) :
                            phase_q == PH_HOLD  ? CW'(T_HOLD - 1) :
                            long_q              ? CW'(T_CLR - 1) : CW'(T_CMD - 1));
        done    = phase_q == PH_WAIT && last;
        if (start) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            rs_d    = rs;
            dat_d   = wr_byte;
            long_d  = long_wait;
        end else if (phase_q != PH_IDLE && last) begin
            phase_d = phase_q == PH_SETUP ? PH_EN : phase_q == PH_EN ? PH_HOLD : phase_q == PH_HOLD ? PH_WAIT : PH_IDLE;
            cnt_d   = '0;
        end
        en_d = phase_d == PH_EN;
    end

    assign lcd_rs  = rs_q;
    assign lcd_en  = en_q;
    assign lcd_dat = dat_q;
endmodule

// File: rtl/lcd_refresh_sequencer.sv
// lcd_refresh_sequencer: 32-cell shadow buffer, power-up/init sequence and continuous two-line LCD refresh
module lcd_refresh_sequencer
    import lcd_pkg::*;
#(
    parameter int T_PWRUP   = 750000,
    parameter int T_SETUP   = 4,
    parameter int T_EN      = 16,
    parameter int T_HOLD    = 4,
    parameter int T_CMD     = 2000,
    parameter int T_CLR     = 82000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [1:0] mode,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat,
    output logic       lcd_n,
    output logic       lcd_p,
    output logic       frame_done
);
    localparam int PW = $clog2(T_PWRUP + 1);
    localparam int BW = $clog2(BLINK_DIV);

    seq_state_e state_q, state_d, nxt_state;
    logic [3:0] idx_q, idx_d, nxt_idx;
    logic [PW-1:0] pwr_q, pwr_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic blink_q, blink_d, wr_ready_q, wr_ready_d, frame_done_q, frame_done_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] buf_q [32];
    logic [7:0] buf_d [32];
    logic [7:0] nxt_byte;
    logic is_char, blanked, long_wait, start, wr_done, blink_wrap, mode_chg;

    lcd_bus_writer #(
        .T_SETUP(T_SETUP),
        .T_EN   (T_EN),
        .T_HOLD (T_HOLD),
        .T_CMD  (T_CMD),
        .T_CLR  (T_CLR)
    ) u_writer (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rs       (is_char),
        .wr_byte  (nxt_byte),
        .long_wait(long_wait),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en),
        .lcd_dat  (lcd_dat),
        .done     (wr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_PWRUP;
            idx_q        <= '0;
            pwr_q        <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            mode_q       <= MODE_NORMAL;
            wr_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            buf_q        <= '{default: LCD_BLANK_CHAR};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pwr_q        <= pwr_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            mode_q       <= mode_d;
            wr_ready_q   <= wr_ready_d;
            frame_done_q <= frame_done_d;
            buf_q        <= buf_d;
        end
    end

    // state_q/idx_q describe the byte on the bus; nxt_* is the byte loaded when start fires.
    always_comb begin
        nxt_state = state_q;
        nxt_idx   = idx_q + 4'd1;
        case (state_q)
            ST_PWRUP: begin nxt_state = ST_INIT; nxt_idx = '0; end
            ST_INIT:  if (idx_q == 4'd3) begin nxt_state = ST_ADDR1; nxt_idx = '0; end
            ST_ADDR1: begin nxt_state = ST_LINE1; nxt_idx = '0; end
            ST_LINE1: if (idx_q == 4'd15) nxt_state = ST_ADDR2;
            ST_ADDR2: begin nxt_state = ST_LINE2; nxt_idx = '0; end
            default:  if (idx_q == 4'd15) nxt_state = ST_ADDR1;
        endcase
        mode_chg  = mode != mode_q;
        is_char   = nxt_state == ST_LINE1 || nxt_state == ST_LINE2;
        blanked   = mode == MODE_BLANK || (mode == MODE_BLINK && !mode_chg && blink_q);
        nxt_byte  = nxt_state == ST_INIT  ? init_cmd(nxt_idx[1:0]) :
                    nxt_state == ST_ADDR1 ? LCD_LINE1 :
                    nxt_state == ST_ADDR2 ? LCD_LINE2 :
                    blanked               ? LCD_BLANK_CHAR : buf_q[{nxt_state == ST_LINE2, nxt_idx}];
        long_wait = !is_char && nxt_byte == LCD_CLEAR;
        start     = (state_q == ST_PWRUP && pwr_q == PW'(T_PWRUP - 1)) || wr_done;
        state_d   = start ? nxt_state : state_q;
        idx_d     = start ? nxt_idx : idx_q;
        pwr_d     = state_q == ST_PWRUP ? pwr_q + PW'(1) : pwr_q;
        frame_done_d = wr_done && state_q == ST_LINE2 && idx_q == 4'd15;
        blink_wrap   = blink_cnt_q == BW'(BLINK_DIV - 1);
        blink_cnt_d  = mode_chg || blink_wrap ? '0 : blink_cnt_q + BW'(1);
        blink_d      = mode_chg ? 1'b0 : blink_q ^ blink_wrap;
        mode_d       = mode;
        wr_ready_d   = 1'b1;
        buf_d        = buf_q;
        if (wr_valid && wr_ready_q) buf_d[wr_addr] = wr_data;
    end

    assign wr_ready   = wr_ready_q;
    assign frame_done = frame_done_q;
    assign lcd_rw     = 1'b0;
    assign lcd_n      = 1'b0;
    assign lcd_p      = 1'b1;
endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// tb_lcd_refresh_sequencer: directed scenarios for init timing, frame content, writes, blink/blank modes and reset
module tb_lcd_refresh_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_valid = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] mode = 2'b00;
    logic wr_ready, lcd_rs, lcd_rw, lcd_en, lcd_n, lcd_p, frame_done;
    logic [7:0] lcd_dat;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int base = 0;
    int frame_start = 0;
    int fd_q[$];
    logic [7:0] exp_cell [32];

    lcd_refresh_sequencer #(
        .T_PWRUP(50), .T_SETUP(2), .T_EN(4), .T_HOLD(2), .T_CMD(8), .T_CLR(20), .BLINK_DIV(1000)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .mode(mode), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_dat(lcd_dat), .lcd_n(lcd_n), .lcd_p(lcd_p), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done) fd_q.push_back(cyc - base);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(output int at, output bit ok);
        logic prev;
        ok = 0;
        at = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            prev = lcd_en;
            tick();
            if (!prev && lcd_en) begin
                ok = 1;
                at = cyc - base;
            end
        end
    endtask

    task automatic run_frame(input string name);
        int at, prev;
        bit ok, found;
        logic [7:0] exp;
        logic exp_rs;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            wait_rise(at, ok);
            if (!ok) break;
            found = lcd_dat === 8'h80 && lcd_rs === 1'b0;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s sync: no 0x80 command seen", name);
            return;
        end
        frame_start = at;
        prev = at;
        for (int k = 0; k < 33; k++) begin
            wait_rise(at, ok);
            exp = k == 16 ? 8'hC0 : exp_cell[k < 16 ? k : k - 1];
            exp_rs = k != 16;
            total++;
            if (!ok || at - prev !== 16 || lcd_dat !== exp || lcd_rs !== exp_rs) begin
                bad++;
                $display("FAIL %s byte %0d: dat=%h rs=%b gap=%0d ok=%0d, want dat=%h rs=%b gap=16",
                         name, k, lcd_dat, lcd_rs, at - prev, ok, exp, exp_rs);
            end
            prev = at;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({lcd_en, lcd_rs, lcd_dat, frame_done, wr_ready} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: en=%b rs=%b dat=%h fd=%b rdy=%b, want all 0",
                     lcd_en, lcd_rs, lcd_dat, frame_done, wr_ready);
        end
        total++;
        if ({lcd_rw, lcd_n, lcd_p} !== 3'b001) begin
            bad++;
            $display("FAIL reset_ties: rw=%b n=%b p=%b, want 0 0 1", lcd_rw, lcd_n, lcd_p);
        end
        rst = 1'b0;
        base = cyc;
        tick();
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b want 1", wr_ready);
        end
    endtask

    task automatic test_init;
        logic [7:0] cmds [4];
        int at, prev;
        bit ok;
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        prev = 36;
        for (int i = 0; i < 4; i++) begin
            wait_rise(at, ok);
            total++;
            if (!ok || at !== prev + 16) begin
                bad++;
                $display("FAIL init_time %0d: rise at %0d ok=%0d, want %0d", i, at, ok, prev + 16);
            end
            total++;
            if (lcd_dat !== cmds[i] || lcd_rs !== 1'b0) begin
                bad++;
                $display("FAIL init_byte %0d: dat=%h rs=%b, want %h rs=0", i, lcd_dat, lcd_rs, cmds[i]);
            end
            prev = at;
        end
    endtask

    task automatic test_idle_frame;
        for (int i = 0; i < 32; i++) exp_cell[i] = 8'h20;
        run_frame("idle");
        total++;
        if (frame_start !== 128) begin
            bad++;
            $display("FAIL line1_cmd_time: rise at %0d, want 128", frame_start);
        end
    endtask

    task automatic test_frame_done;
        for (int i = 0; i < 2000 && fd_q.size() < 2; i++) tick();
        total++;
        if (fd_q.size() < 2) begin
            bad++;
            $display("FAIL frame_done_count: got %0d pulses, want 2", fd_q.size());
        end else begin
            total++;
            if (fd_q[0] !== 670 || fd_q[1] !== 1214) begin
                bad++;
                $display("FAIL frame_done_time: got %0d,%0d want 670,1214", fd_q[0], fd_q[1]);
            end
        end
    endtask

    task automatic test_write;
        wr_valid = 1'b1;
        wr_addr = 5'd0;
        wr_data = 8'h46;
        tick();
        wr_addr = 5'd17;
        wr_data = 8'h72;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 32; i++) exp_cell[i] = 8'h20;
        exp_cell[0] = 8'h46;
        exp_cell[17] = 8'h72;
        run_frame("write");
    endtask

    task automatic test_blink;
        int at, e0, r, ph, nblank, nchar;
        bit ok;
        logic [7:0] exp;
        wr_valid = 1'b1;
        for (int a = 0; a < 32; a++) begin
            wr_addr = 5'(a);
            wr_data = 8'h41;
            tick();
        end
        wr_valid = 1'b0;
        tick();
        tick();
        tick();
        mode = 2'b01;
        e0 = cyc;
        nblank = 0;
        nchar = 0;
        while (cyc - e0 < 2600) begin
            wait_rise(at, ok);
            r = cyc;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL blink_timeout: no E rise");
                break;
            end
            if (lcd_rs) begin
                ph = ((r - e0 - 4) / 1000) & 1;
                exp = ph != 0 ? 8'h20 : 8'h41;
                if (ph != 0) nblank++; else nchar++;
                if (lcd_dat !== exp) begin
                    bad++;
                    $display("FAIL blink_char at +%0d: dat=%h want %h", r - e0, lcd_dat, exp);
                end
            end else if (lcd_dat !== 8'h80 && lcd_dat !== 8'hC0) begin
                bad++;
                $display("FAIL blink_cmd at +%0d: dat=%h want 80 or C0", r - e0, lcd_dat);
            end
        end
        total++;
        if (nblank == 0 || nchar == 0) begin
            bad++;
            $display("FAIL blink_phases: blank=%0d char=%0d, want both nonzero", nblank, nchar);
        end
    endtask

    task automatic test_blank;
        int at, e1, r;
        bit ok;
        logic [7:0] exp;
        mode = 2'b10;
        e1 = cyc;
        while (cyc - e1 < 600) begin
            wait_rise(at, ok);
            r = cyc;
            if (!ok) break;
            if (lcd_rs && r >= e1 + 3) begin
                total++;
                if (lcd_dat !== 8'h20) begin
                    bad++;
                    $display("FAIL blank_char at +%0d: dat=%h want 20", r - e1, lcd_dat);
                end
            end
        end
        mode = 2'b00;
        e1 = cyc;
        while (cyc - e1 < 300) begin
            wait_rise(at, ok);
            r = cyc;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL unblank_timeout: no E rise");
                break;
            end
            exp = r >= e1 + 3 ? 8'h41 : 8'h20;
            if (lcd_rs && lcd_dat !== exp) begin
                bad++;
                $display("FAIL unblank_char at +%0d: dat=%h want %h", r - e1, lcd_dat, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        int at;
        bit ok;
        wait_rise(at, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL midreset_rise: no E rise before reset");
        end
        rst = 1'b1;
        tick();
        total++;
        if (lcd_en !== 1'b0 || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL midreset_en: en=%b rdy=%b, want 0 0", lcd_en, wr_ready);
        end
        rst = 1'b0;
        base = cyc;
        fd_q.delete();
        wait_rise(at, ok);
        total++;
        if (!ok || at !== 52 || lcd_dat !== 8'h38 || lcd_rs !== 1'b0) begin
            bad++;
            $display("FAIL midreset_init: rise at %0d dat=%h rs=%b, want 52 38 0", at, lcd_dat, lcd_rs);
        end
        for (int i = 0; i < 32; i++) exp_cell[i] = 8'h20;
        run_frame("after_reset");
        total++;
        if (frame_start !== 128) begin
            bad++;
            $display("FAIL midreset_line1: rise at %0d, want 128", frame_start);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_idle_frame();
        test_frame_done();
        test_write();
        test_blink();
        test_blank();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
